// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the unified memory arbiter:
//               FSM state encoding, port identifiers and parameter defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Access sequencer states; ST_ prefix keeps the names clear of the WAIT parameter
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Port identifiers, also used as the round-robin pointer value
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Default geometry and timing
    localparam int DEPTH_DEFAULT = 1024;
    localparam int WAIT_DEFAULT  = 1;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : Single-port synchronous word RAM with per-byte write enables.
//               Read data is registered and reflects the word before any
//               write in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Enabled access: registered read plus lane-masked write
    always_ff @(posedge clk) begin
        if (en) begin
            r_rdata <= r_mem[addr];
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    assign rdata = r_rdata;

endmodule : mem_array
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Round-robin arbiter giving an instruction-fetch port and a
//               load/store port shared access to one single-port word RAM.
//               One access in flight; acks, err and read data are registered
//               at the end of the response cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WAIT  = WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);
    // Counter value on which the last wait cycle ends
    localparam logic [2:0] C_WAIT_LAST = (WAIT == 0) ? 3'd0 : 3'(WAIT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_wcnt;
    logic            r_rr_d;
    logic            r_port;
    logic            r_we;
    logic            r_err;
    logic [3:0]      r_be;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;

    logic            w_grant;
    logic            w_gport;
    logic [31:0]     w_gaddr;
    logic            w_gerr;
    logic            w_mem_en;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [31:0]     w_mem_rdata;

    // Arbitration: a lone request wins outright, a tie goes to the pointer
    always_comb begin
        w_grant = if_req | d_req;
        if (if_req && d_req) begin
            w_gport = r_rr_d ? PORT_D : PORT_IF;
        end else begin
            w_gport = d_req ? PORT_D : PORT_IF;
        end
        w_gaddr = (w_gport == PORT_D) ? d_addr : if_addr;
        w_gerr  = (|w_gaddr[31:AW+2]) |
                  ((w_gport == PORT_IF) & (|w_gaddr[1:0]));
    end

    // Next-state logic of the access sequencer
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_next = (WAIT == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_wcnt == C_WAIT_LAST) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register and wait-cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_wcnt  <= 3'd0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= (r_state == ST_WAIT) ? r_wcnt + 3'd1 : 3'd0;
        end
    end

    // Round-robin pointer: after any grant the other port has priority
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_d <= PORT_D;
        end else if (r_state == ST_IDLE && w_grant) begin
            r_rr_d <= (w_gport == PORT_IF) ? PORT_D : PORT_IF;
        end
    end

    // Capture the granted transaction so later input changes are ignored
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && w_grant) begin
            r_port  <= w_gport;
            r_idx   <= w_gaddr[AW+1:2];
            r_err   <= w_gerr;
            r_we    <= (w_gport == PORT_D) & d_we;
            r_be    <= d_be;
            r_wdata <= d_wdata;
        end
    end

    // The RAM reads on the grant edge and every busy edge, so the word is
    // ready in the response cycle even with no wait states; the write is
    // committed only on the response edge and is dropped under reset or error.
    assign w_mem_en   = (r_state != ST_IDLE) | w_grant;
    assign w_mem_addr = (r_state == ST_IDLE) ? w_gaddr[AW+1:2] : r_idx;
    assign w_mem_we   = (r_state == ST_RESP) & r_we & ~r_err & ~reset;

    mem_array #(
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .en    (w_mem_en),
        .we    (w_mem_we),
        .be    (r_be),
        .addr  (w_mem_addr),
        .wdata (r_wdata),
        .rdata (w_mem_rdata)
    );

    // Response registers: one-cycle ack/err pulse, per-port read data hold
    always_ff @(posedge clk) begin
        if (reset) begin
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            err      <= 1'b0;
            if_rdata <= 32'd0;
            d_rdata  <= 32'd0;
        end else if (r_state == ST_RESP) begin
            if_ack <= (r_port == PORT_IF);
            d_ack  <= (r_port == PORT_D);
            err    <= r_err;
            if (r_port == PORT_IF) begin
                if_rdata <= r_err ? 32'd0 : w_mem_rdata;
            end else begin
                d_rdata  <= r_err ? 32'd0 : w_mem_rdata;
            end
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            err    <= 1'b0;
        end
    end

endmodule : unified_mem_arbiter
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_mem_arbiter
// Description : Scoreboard bench for unified_mem_arbiter. Main instance uses
//               WAIT=1; two extra instances measure WAIT=0 / WAIT=7 latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;
    import mem_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic [31:0] if_rdata, d_rdata;
    logic        if_ack, d_ack, err;

    // Extra instances: fetch port only, data port tied off
    logic        tie0 = 1'b0;
    logic [3:0]  tie4 = 4'd0;
    logic [31:0] tie32 = 32'd0;
    logic        w0_if_req, w7_if_req;
    logic [31:0] w0_if_rdata, w0_d_rdata, w7_if_rdata, w7_d_rdata;
    logic        w0_if_ack, w0_d_ack, w0_err, w7_if_ack, w7_d_ack, w7_err;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.DEPTH(DEPTH), .WAIT(1)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .err(err)
    );

    unified_mem_arbiter #(.DEPTH(DEPTH), .WAIT(0)) u_dut_w0 (
        .clk(clk), .reset(reset),
        .if_req(w0_if_req), .if_addr(32'h10), .if_rdata(w0_if_rdata), .if_ack(w0_if_ack),
        .d_req(tie0), .d_we(tie0), .d_be(tie4), .d_addr(tie32), .d_wdata(tie32),
        .d_rdata(w0_d_rdata), .d_ack(w0_d_ack), .err(w0_err)
    );

    unified_mem_arbiter #(.DEPTH(DEPTH), .WAIT(7)) u_dut_w7 (
        .clk(clk), .reset(reset),
        .if_req(w7_if_req), .if_addr(32'h10), .if_rdata(w7_if_rdata), .if_ack(w7_if_ack),
        .d_req(tie0), .d_we(tie0), .d_be(tie4), .d_addr(tie32), .d_wdata(tie32),
        .d_rdata(w7_d_rdata), .d_ack(w7_d_ack), .err(w7_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        port;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [int];

    // Build the expected response for an access and update the memory model
    task automatic push_expect(input logic port, input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int          idx;
        logic [31:0] w;
        idx     = int'(addr >> 2);
        e.port  = port;
        e.err   = (addr >= 32'(4 * DEPTH)) || (port == PORT_IF && (addr % 4) != 0);
        e.chk   = 1'b0;
        e.rdata = 32'd0;
        if (port == PORT_D && we) begin
            if (!e.err) begin
                w = model.exists(idx) ? model[idx] : 32'd0;
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
                end
                model[idx] = w;
            end
        end else if (e.err) begin
            e.chk = 1'b1;
        end else if (model.exists(idx)) begin
            e.chk   = 1'b1;
            e.rdata = model[idx];
        end
        sb.push_back(e);
    endtask

    // Issue one access, hold the request until its ack, check latency
    task automatic access(input logic port, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat);
        int   lat;
        logic got;
        push_expect(port, we, be, addr, wdata);
        @(posedge clk); #1;
        if (port == PORT_D) begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if ((port == PORT_D) ? d_ack : if_ack) got = 1'b1;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check("ack_seen", {31'd0, got}, 32'd1);
        if (!got) void'(sb.pop_back());
        else if (exp_lat > 0) check("latency", lat, exp_lat);
    endtask

    // Scoreboard consumer: every ack pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (if_ack || d_ack) begin
            check("ack_excl", {31'd0, if_ack & d_ack}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, if_ack, d_ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_port", {31'd0, d_ack}, {31'd0, e.port});
                check("ack_err", {31'd0, err}, {31'd0, e.err});
                if (e.chk) check("rdata", (e.port == PORT_D) ? d_rdata : if_rdata, e.rdata);
            end
        end
    end

    // Lone fetch latency on one of the extra instances
    task automatic lone_fetch(input int sel, input int exp_lat);
        int   lat;
        logic got;
        @(posedge clk); #1;
        if (sel == 0) w0_if_req = 1'b1; else w7_if_req = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if ((sel == 0) ? w0_if_ack : w7_if_ack) got = 1'b1;
        end
        check((sel == 0) ? "w0_err" : "w7_err", {31'd0, (sel == 0) ? w0_err : w7_err}, 32'd0);
        w0_if_req = 1'b0;
        w7_if_req = 1'b0;
        check((sel == 0) ? "w0_latency" : "w7_latency", got ? lat : -1, exp_lat);
    endtask

    initial begin
        int n;
        int cyc;
        reset = 1'b1;
        if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'd0; d_addr = 32'd0; d_wdata = 32'd0;
        w0_if_req = 1'b0; w7_if_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_if_ack", {31'd0, if_ack}, 32'd0);
        check("rst_d_ack", {31'd0, d_ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);

        // Full store then load, with latency
        access(PORT_D, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 3);
        access(PORT_D, 1'b0, 4'b0000, 32'h10, 32'h0, 3);
        // Single-lane store, then fetch; data port keeps its last load word
        access(PORT_D, 1'b1, 4'b0010, 32'h10, 32'h0000AB00, 3);
        access(PORT_IF, 1'b0, 4'b0000, 32'h10, 32'h0, 3);
        @(negedge clk);
        check("d_rdata_hold", d_rdata, 32'hDEADBEEF);
        // Empty byte mask leaves the word alone
        access(PORT_D, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 0);
        access(PORT_IF, 1'b0, 4'b0000, 32'h10, 32'h0, 0);
        // Unaligned data address uses the word index only
        access(PORT_D, 1'b0, 4'b0000, 32'h12, 32'h0, 0);
        // Top word of the array and the errors just past it
        access(PORT_D, 1'b1, 4'b1111, 32'hFFC, 32'hCAFEF00D, 0);
        access(PORT_D, 1'b0, 4'b0000, 32'hFFC, 32'h0, 0);
        access(PORT_D, 1'b0, 4'b0000, 32'h1000, 32'h0, 0);
        access(PORT_IF, 1'b0, 4'b0000, 32'h2, 32'h0, 0);
        access(PORT_D, 1'b1, 4'b1111, 32'h1000, 32'h12345678, 0);
        access(PORT_D, 1'b0, 4'b0000, 32'h0, 32'h0, 0);

        // Store abandoned by reset in its response cycle
        access(PORT_D, 1'b1, 4'b1111, 32'h20, 32'h11111111, 0);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b1111; d_addr = 32'h20; d_wdata = 32'h22222222;
        @(posedge clk);          // grant
        @(posedge clk); #1;      // now in the response cycle
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_resp_no_ack", {31'd0, d_ack}, 32'd0);
        d_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        access(PORT_D, 1'b0, 4'b0000, 32'h20, 32'h0, 3);

        // Both ports held from reset release: d, if, d, if
        reset = 1'b1;
        @(posedge clk); #1;
        push_expect(PORT_D, 1'b0, 4'b0000, 32'h20, 32'h0);
        push_expect(PORT_IF, 1'b0, 4'b0000, 32'h10, 32'h0);
        push_expect(PORT_D, 1'b0, 4'b0000, 32'h20, 32'h0);
        push_expect(PORT_IF, 1'b0, 4'b0000, 32'h10, 32'h0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h10;
        @(posedge clk); #1;
        reset = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (if_ack || d_ack) n++;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check("rr_ack_count", n, 4);

        // Wait-state extremes
        lone_fetch(0, 2);
        lone_fetch(1, 9);

        repeat (4) @(posedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_unified_mem_arbiter
`default_nettype wire
